// File: rtl/sig_control.sv
// Moore traffic-light controller for a highway / country-road crossing.
// The highway rests on green. A car on the country road starts the yellow, all-red, country-green sequence.
module sig_control #(
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] o_state
);

    localparam int MAX_DELAY = (Y2R_DELAY > R2G_DELAY) ? Y2R_DELAY : R2G_DELAY;
    localparam int CW        = $clog2(MAX_DELAY) + 1;

    localparam logic [CW-1:0] Y2R_LAST = CW'(Y2R_DELAY - 1);
    localparam logic [CW-1:0] R2G_LAST = CW'(R2G_DELAY - 1);

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
        end
    end

    // The counter only advances while a timed state is dwelling; every exit reloads it with zero.
    always_comb begin
        w_next       = r_state;
        w_count_next = '0;
        hwy          = LAMP_GREEN;
        cntry        = LAMP_RED;
        case (r_state)
            S0: begin
                if (X) begin
                    w_next = S1;
                end
            end
            S1: begin
                hwy = LAMP_YELLOW;
                if (r_count == Y2R_LAST) begin
                    w_next = S2;
                end else begin
                    w_count_next = r_count + CW'(1);
                end
            end
            S2: begin
                hwy = LAMP_RED;
                if (r_count == R2G_LAST) begin
                    w_next = S3;
                end else begin
                    w_count_next = r_count + CW'(1);
                end
            end
            S3: begin
                hwy   = LAMP_RED;
                cntry = LAMP_GREEN;
                if (!X) begin
                    w_next = S4;
                end
            end
            S4: begin
                hwy   = LAMP_RED;
                cntry = LAMP_YELLOW;
                if (r_count == Y2R_LAST) begin
                    w_next = S0;
                end else begin
                    w_count_next = r_count + CW'(1);
                end
            end
            default: begin
                w_next = S0;
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_sig_control.sv
// Bench for sig_control: plan-timed checks, a vector table, corner sequences and random traffic.
// The reference model is a schedule queue of upcoming lamp pairs.
module tb_sig_control;

    localparam int Y2R = 3;
    localparam int R2G = 2;

    logic       clock = 1'b0;
    logic       clear;
    logic       X;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] dbg_state;

    sig_control #(
        .Y2R_DELAY(Y2R),
        .R2G_DELAY(R2G)
    ) dut (
        .clock  (clock),
        .clear  (clear),
        .X      (X),
        .hwy    (hwy),
        .cntry  (cntry),
        .o_state(dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       x;
        logic [1:0] h;
        logic [1:0] c;
    } vec_t;

    vec_t tbl[22];

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] sched[$];
    logic [1:0] m_h;
    logic [1:0] m_c;

    int plan_off[5] = '{5, 35, 55, 105, 135};
    int plan_h[5]   = '{1, 0, 0, 0, 2};
    int plan_c[5]   = '{0, 0, 2, 1, 0};
    int plan_base[3] = '{200, 500, 800};

    task automatic check2(input string name, input logic [1:0] h, input logic [1:0] c);
        n_vec++;
        if (hwy !== h || cntry !== c) begin
            n_err++;
            $display("FAIL %s @%0t: hwy=%0d cntry=%0d, required hwy=%0d cntry=%0d",
                     name, $time, hwy, cntry, h, c);
        end
    endtask

    task automatic check_safe();
        n_vec++;
        if (hwy === 2'd3 || cntry === 2'd3 || (hwy !== 2'd0 && cntry !== 2'd0)) begin
            n_err++;
            $display("FAIL lamp_conflict @%0t: hwy=%0d cntry=%0d, required one of them RED",
                     $time, hwy, cntry);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        m_h = 2'd2;
        m_c = 2'd0;
    endtask

    // Once the schedule runs dry the lights rest on a green, waiting for the sensor to ask for a change.
    task automatic model_step();
        if (sched.size() == 0) begin
            if (m_h == 2'd2 && X) begin
                repeat (Y2R) sched.push_back({2'd1, 2'd0});
                repeat (R2G) sched.push_back({2'd0, 2'd0});
                sched.push_back({2'd0, 2'd2});
            end else if (m_c == 2'd2 && !X) begin
                repeat (Y2R) sched.push_back({2'd0, 2'd1});
                sched.push_back({2'd2, 2'd0});
            end
        end
        if (sched.size() > 0) begin
            {m_h, m_c} = sched.pop_front();
        end
    endtask

    task automatic check_timed();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 5; k++) begin
                if ($time == 64'(plan_base[b] + plan_off[k] + 1)) begin
                    check2("plan_timing", plan_h[k][1:0], plan_c[k][1:0]);
                end
            end
        end
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic cycle(input logic x, input string name);
        X = x;
        @(posedge clock);
        model_step();
        #1;
        check2(name, m_h, m_c);
        check_safe();
        check_timed();
        @(negedge clock);
    endtask

    function automatic logic plan_x(input longint t);
        return (t >= 200 && t < 300) || (t >= 500 && t < 600) || (t >= 800 && t < 900);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog @%0t: simulation did not finish, required end before 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // X toggles during S1/S2/S4 are ignored; one-cycle S3 when X is low on arrival.
        tbl[0]  = '{1'b0, 2'd2, 2'd0};
        tbl[1]  = '{1'b1, 2'd1, 2'd0};
        tbl[2]  = '{1'b0, 2'd1, 2'd0};
        tbl[3]  = '{1'b1, 2'd1, 2'd0};
        tbl[4]  = '{1'b0, 2'd0, 2'd0};
        tbl[5]  = '{1'b1, 2'd0, 2'd0};
        tbl[6]  = '{1'b0, 2'd0, 2'd2};
        tbl[7]  = '{1'b0, 2'd0, 2'd1};
        tbl[8]  = '{1'b1, 2'd0, 2'd1};
        tbl[9]  = '{1'b1, 2'd0, 2'd1};
        tbl[10] = '{1'b1, 2'd2, 2'd0};
        tbl[11] = '{1'b1, 2'd1, 2'd0};
        tbl[12] = '{1'b0, 2'd1, 2'd0};
        tbl[13] = '{1'b0, 2'd1, 2'd0};
        tbl[14] = '{1'b0, 2'd0, 2'd0};
        tbl[15] = '{1'b0, 2'd0, 2'd0};
        tbl[16] = '{1'b1, 2'd0, 2'd2};
        tbl[17] = '{1'b1, 2'd0, 2'd2};
        tbl[18] = '{1'b0, 2'd0, 2'd1};
        tbl[19] = '{1'b1, 2'd0, 2'd1};
        tbl[20] = '{1'b0, 2'd0, 2'd1};
        tbl[21] = '{1'b0, 2'd2, 2'd0};

        clear = 1'b0;
        X     = 1'b0;
        model_reset();
        #1;
        check2("reset_t1", 2'd2, 2'd0);
        check_safe();
        #15;
        check2("reset_held", 2'd2, 2'd0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;

        while ($time < 1000) begin
            cycle(plan_x($time), "plan_model");
        end

        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].x, "table_model");
            check2("table_vec", tbl[i].h, tbl[i].c);
        end

        repeat (7) cycle(1'b1, "to_s3");
        check2("in_s3", 2'd0, 2'd2);
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        check2("clear_mid_s3", 2'd2, 2'd0);
        check_safe();
        X = 1'b1;
        #1;
        clear = 1'b1;
        @(posedge clock);
        model_step();
        #1;
        check2("s1_after_clear", 2'd1, 2'd0);
        check2("s1_after_clear_model", m_h, m_c);
        @(negedge clock);

        repeat (400) begin
            if ($urandom_range(0, 59) == 0) begin
                clear = 1'b0;
                #1;
                model_reset();
                check2("rand_clear", 2'd2, 2'd0);
                #1;
                clear = 1'b1;
            end
            cycle(1'($urandom_range(0, 1)), "random_model");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
